// File: rtl/trade_report_tx_if.sv
// ---------------------------------------------------------------------------
// trade_report_tx_if
//   GPIO handshake bundle between the trade report transmitter and the
//   software-driven host.
//   tx_word  : 16-bit word presented to the GPIO input bus
//   tx_req   : high while tx_word is valid and awaiting acknowledge
//   host_ack : 4-phase acknowledge driven by a software GPIO bit
//   master   : transmitter side; slave : host side
// ---------------------------------------------------------------------------
interface trade_report_tx_if;
  logic [15:0] tx_word;
  logic        tx_req;
  logic        host_ack;

  modport master (output tx_word, output tx_req, input host_ack);
  modport slave  (input tx_word, input tx_req, output host_ack);
endinterface

// File: rtl/trade_report_tx.sv
// ---------------------------------------------------------------------------
// trade_report_tx
//   Return path from the trading core to the processor subsystem. Detects
//   rising buy/sell decisions, snapshots {buy, sell, stock_id, seq, profit}
//   into a small FIFO and streams each event as a header word followed by a
//   profit word over a 4-phase req/ack handshake.
//
// Ports
//   clk         : system clock, shared with processor GPIO
//   rst         : asynchronous active-low reset
//   buy_signal  : buy decision from the trading core
//   sell_signal : sell decision from the trading core
//   stock_id    : stock identifier accompanying a decision
//   profit      : running profit, sampled with the event
//   tx_if       : handshake bundle (tx_word, tx_req out; host_ack in)
//   fifo_level  : number of queued events
//   drop_count  : events lost to a full FIFO, saturating at all-ones
//   busy        : high whenever the transmit FSM is not in IDLE
//
// Build option
//   ACK_SYNC_EN : when defined, host_ack passes a 2-flop synchronizer before
//                 the FSM (2 extra cycles per ack transition).
// ---------------------------------------------------------------------------
module trade_report_tx #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   buy_signal,
  input  logic                   sell_signal,
  input  logic [1:0]             stock_id,
  input  logic [15:0]            profit,
  trade_report_tx_if.master      tx_if,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_REQ = 3'd1,
    HDR_REL = 3'd2,
    PAY_REQ = 3'd3,
    PAY_REL = 3'd4
  } state_t;

  // Header word: sync nibble, decision flags, stock id, low 8 bits of seq.
  function automatic logic [15:0] make_header(input logic       buy,
                                              input logic       sell,
                                              input logic [1:0] id,
                                              input logic [7:0] seq);
    return {4'hA, buy, sell, id, seq};
  endfunction

  logic             prev_buy_r;
  logic             prev_sell_r;
  logic [CNT_W-1:0] seq_r;
  logic [CNT_W-1:0] drop_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [31:0]      mem_r [DEPTH];
  state_t           state_r;
  logic [15:0]      tx_word_r;
  logic             tx_req_r;
  logic             busy_r;
  logic [15:0]      pay_r;

  logic             ev_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             ack_s;
  logic [7:0]       seq_hdr_s;
  logic [31:0]      wr_rec_s;
  logic [31:0]      rd_rec_s;

  // Header carries exactly 8 sequence bits regardless of CNT_W.
  if (CNT_W >= 8) begin : g_seq_wide
    assign seq_hdr_s = seq_r[7:0];
  end else begin : g_seq_narrow
    assign seq_hdr_s = {{(8-CNT_W){1'b0}}, seq_r};
  end

`ifdef ACK_SYNC_EN
  logic ack_meta_r;
  logic ack_sync_r;

  // Two-flop synchronizer for the software-driven acknowledge bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_meta_r <= 1'b0;
      ack_sync_r <= 1'b0;
    end else begin
      ack_meta_r <= tx_if.host_ack;
      ack_sync_r <= ack_meta_r;
    end
  end
  assign ack_s = ack_sync_r;
`else
  assign ack_s = tx_if.host_ack;
`endif

  // Event detect, FIFO push/pop decisions and the record to be queued.
  always_comb begin
    ev_s     = (buy_signal | sell_signal) & ~(prev_buy_r | prev_sell_r);
    pop_s    = (state_r == IDLE) && (level_r != {LVL_W{1'b0}});
    // A full FIFO still accepts the event when a slot frees on the same edge.
    push_s   = ev_s && ((level_r < DEPTH_L) || pop_s);
    drop_s   = ev_s && !push_s;
    wr_rec_s = {make_header(buy_signal, sell_signal, stock_id, seq_hdr_s), profit};
  end

  assign rd_rec_s = mem_r[rd_ptr_r];

  // Edge-detect history, sequence number and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_buy_r  <= 1'b0;
      prev_sell_r <= 1'b0;
      seq_r       <= {CNT_W{1'b0}};
      drop_r      <= {CNT_W{1'b0}};
    end else begin
      prev_buy_r  <= buy_signal;
      prev_sell_r <= sell_signal;
      // Dropped events still consume a sequence number so gaps are visible.
      if (ev_s) begin
        seq_r <= seq_r + CNT_W'(1);
      end
      if (drop_s && (drop_r != {CNT_W{1'b1}})) begin
        drop_r <= drop_r + CNT_W'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_rec_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && !pop_s) begin
        level_r <= level_r + LVL_W'(1);
      end else if (pop_s && !push_s) begin
        level_r <= level_r - LVL_W'(1);
      end
    end
  end

  // Transmit FSM: header then payload, each over a full 4-phase handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      tx_word_r <= 16'h0000;
      tx_req_r  <= 1'b0;
      busy_r    <= 1'b0;
      pay_r     <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            tx_word_r <= rd_rec_s[31:16];
            pay_r     <= rd_rec_s[15:0];
            tx_req_r  <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= HDR_REQ;
          end
        end
        HDR_REQ: begin
          if (ack_s) begin
            tx_req_r <= 1'b0;
            state_r  <= HDR_REL;
          end
        end
        HDR_REL: begin
          if (!ack_s) begin
            tx_word_r <= pay_r;
            tx_req_r  <= 1'b1;
            state_r   <= PAY_REQ;
          end
        end
        PAY_REQ: begin
          if (ack_s) begin
            tx_req_r <= 1'b0;
            state_r  <= PAY_REL;
          end
        end
        PAY_REL: begin
          if (!ack_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          tx_req_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign tx_if.tx_word = tx_word_r;
  assign tx_if.tx_req  = tx_req_r;
  assign fifo_level    = level_r;
  assign drop_count    = drop_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_trade_report_tx.sv
// ---------------------------------------------------------------------------
// tb_trade_report_tx
//   Self-checking bench for trade_report_tx (DEPTH=8, CNT_W=8). A table of
//   single-event vectors covers the word format and handshake timing;
//   hand-written sequences cover back-pressure with drops and counter
//   saturation, back-to-back events, and asynchronous reset mid-transfer.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_trade_report_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        buy_signal = 1'b0;
  logic        sell_signal = 1'b0;
  logic [1:0]  stock_id = 2'd0;
  logic [15:0] profit = 16'h0000;
  logic [3:0]  fifo_level;
  logic [7:0]  drop_count;
  logic        busy;

  trade_report_tx_if tx_if ();

  trade_report_tx #(.DEPTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .buy_signal (buy_signal),
    .sell_signal(sell_signal),
    .stock_id   (stock_id),
    .profit     (profit),
    .tx_if      (tx_if),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

`ifdef ACK_SYNC_EN
  localparam int ACK_LAT = 3;
`else
  localparam int ACK_LAT = 1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        buy;
    logic        sell;
    logic [1:0]  id;
    logic [15:0] pr;
    int          hold;
    int          dly;
    logic [15:0] hdr;
    logic [15:0] pay;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input logic val, input string name);
    int i = 0;
    while (tx_if.tx_req !== val && i < 100) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(tx_if.tx_req), 32'(val));
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy !== 1'b0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // One word of the 4-phase handshake: wait for req, ack after dly cycles,
  // report the word and how many cycles req took to fall after ack.
  task automatic xfer(input int dly, output logic [15:0] word, output int fall);
    wait_req(1'b1, "req_rise");
    word = tx_if.tx_word;
    repeat (dly) @(negedge clk);
    tx_if.host_ack = 1'b1;
    fall = 0;
    do begin
      @(negedge clk);
      fall++;
    end while (tx_if.tx_req === 1'b1 && fall < 100);
    check("word_hold", 32'(tx_if.tx_word), 32'(word));
    tx_if.host_ack = 1'b0;
  endtask

  task automatic pulse(input logic b, input logic s, input logic [1:0] id, input logic [15:0] pr);
    buy_signal  = b;
    sell_signal = s;
    stock_id    = id;
    profit      = pr;
    @(negedge clk);
    buy_signal  = 1'b0;
    sell_signal = 1'b0;
    @(negedge clk);
  endtask

  // Called on a falling edge; reset asserts mid low phase, away from posedge.
  task automatic do_reset();
    buy_signal     = 1'b0;
    sell_signal    = 1'b0;
    tx_if.host_ack = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_tx_req", 32'(tx_if.tx_req), 32'd0);
    check("rst_tx_word", 32'(tx_if.tx_word), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          f;
    int          idle;
    int          rise;

    //            buy   sell  id    profit    hold dly header    payload
    vecs[0] = '{1'b1, 1'b0, 2'd2, 16'h0123, 1,   3,  16'hAA00, 16'h0123};
    vecs[1] = '{1'b0, 1'b1, 2'd0, 16'hFFFF, 1,   0,  16'hA401, 16'hFFFF};
    vecs[2] = '{1'b1, 1'b0, 2'd3, 16'h8000, 3,   1,  16'hAB02, 16'h8000};
    vecs[3] = '{1'b1, 1'b1, 2'd1, 16'h0042, 5,   2,  16'hAD03, 16'h0042};
    vecs[4] = '{1'b0, 1'b1, 2'd3, 16'h7FFF, 1,   0,  16'hA704, 16'h7FFF};

    tx_if.host_ack = 1'b0;
    @(negedge clk);
    do_reset();

    // Table: one event each, exact latency, word contents and ack timing.
    for (int v = 0; v < 5; v++) begin
      buy_signal  = vecs[v].buy;
      sell_signal = vecs[v].sell;
      stock_id    = vecs[v].id;
      profit      = vecs[v].pr;
      for (int c = 1; c <= ((vecs[v].hold > 2) ? vecs[v].hold : 2); c++) begin
        @(negedge clk);
        if (c == 1) begin
          check("lvl_after_event", 32'(fifo_level), 32'd1);
          check("req_before_pop", 32'(tx_if.tx_req), 32'd0);
        end
        if (c == 2) begin
          check("req_at_k1", 32'(tx_if.tx_req), 32'd1);
          check("lvl_after_pop", 32'(fifo_level), 32'd0);
          check("busy_at_k1", 32'(busy), 32'd1);
        end
        if (c == vecs[v].hold) begin
          buy_signal  = 1'b0;
          sell_signal = 1'b0;
        end
      end
      xfer(vecs[v].dly, w, f);
      check("vec_header", 32'(w), 32'(vecs[v].hdr));
      check("vec_hdr_ack_lat", 32'(f), 32'(ACK_LAT));
      xfer(vecs[v].dly, w, f);
      check("vec_payload", 32'(w), 32'(vecs[v].pay));
      check("vec_pay_ack_lat", 32'(f), 32'(ACK_LAT));
      wait_idle();
      check("vec_lvl_end", 32'(fifo_level), 32'd0);
      check("vec_drop_end", 32'(drop_count), 32'd0);
    end

    // Back-pressure: ack held low, fill FIFO, drop, saturate drop counter.
    do_reset();
    pulse(1'b1, 1'b0, 2'd0, 16'd0);
    check("bp_first_pop_lvl", 32'(fifo_level), 32'd0);
    check("bp_first_pop_req", 32'(tx_if.tx_req), 32'd1);
    for (int i = 1; i < 10; i++) begin
      pulse(1'b1, 1'b0, 2'd0, 16'(i));
    end
    check("bp_full_lvl", 32'(fifo_level), 32'd8);
    check("bp_drop_one", 32'(drop_count), 32'd1);
    for (int i = 0; i < 260; i++) begin
      pulse(1'b1, 1'b0, 2'd0, 16'hDEAD);
    end
    check("bp_drop_sat", 32'(drop_count), 32'd255);
    check("bp_full_lvl2", 32'(fifo_level), 32'd8);
    for (int i = 0; i < 9; i++) begin
      xfer(0, w, f);
      check("bp_header", 32'(w), 32'(16'hA800 | 16'(i)));
      xfer(0, w, f);
      check("bp_payload", 32'(w), 32'(i));
    end
    wait_idle();
    check("bp_drain_lvl", 32'(fifo_level), 32'd0);
    check("bp_drop_hold", 32'(drop_count), 32'd255);
    // 270 events so far: sequence has wrapped to 14.
    pulse(1'b1, 1'b0, 2'd0, 16'h5555);
    xfer(0, w, f);
    check("wrap_header", 32'(w), 32'h0000A80E);
    xfer(0, w, f);
    check("wrap_payload", 32'(w), 32'h00005555);
    wait_idle();

    // Back-to-back: second header after exactly one IDLE cycle.
    pulse(1'b1, 1'b0, 2'd1, 16'h1111);
    pulse(1'b0, 1'b1, 2'd2, 16'h2222);
    xfer(0, w, f);
    check("b2b_hdr_a", 32'(w), 32'h0000A90F);
    xfer(0, w, f);
    check("b2b_pay_a", 32'(w), 32'h00001111);
    idle = 0;
    rise = 0;
    while (tx_if.tx_req !== 1'b1 && rise < 100) begin
      @(negedge clk);
      rise++;
      if (busy === 1'b0) idle++;
    end
    check("b2b_idle_cycles", 32'(idle), 32'd1);
    xfer(0, w, f);
    check("b2b_hdr_b", 32'(w), 32'h0000A610);
    xfer(0, w, f);
    check("b2b_pay_b", 32'(w), 32'h00002222);
    wait_idle();

    // Reset while in PAY_REQ with two records queued.
    pulse(1'b1, 1'b0, 2'd0, 16'h0001);
    pulse(1'b0, 1'b1, 2'd1, 16'h0002);
    pulse(1'b1, 1'b0, 2'd3, 16'h0003);
    check("rst_seq_lvl2", 32'(fifo_level), 32'd2);
    xfer(0, w, f);
    wait_req(1'b1, "rst_seq_payreq");
    check("rst_seq_pay_word", 32'(tx_if.tx_word), 32'h00000001);
    do_reset();
    pulse(1'b1, 1'b0, 2'd3, 16'hBEEF);
    xfer(1, w, f);
    check("post_rst_header", 32'(w), 32'h0000AB00);
    xfer(1, w, f);
    check("post_rst_payload", 32'(w), 32'h0000BEEF);
    wait_idle();
    check("post_rst_lvl", 32'(fifo_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
